// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that decodes aluop/funct, drives a combinational ALU,
// waits SETTLE_CYCLES edges and returns the sampled result. Optional check: ALU_SEQ_SELFCHECK_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic             rsp_mismatch
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_f_q, alu_f_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_illegal_q, rsp_illegal_d;
  logic               rsp_mismatch_q, rsp_mismatch_d;

  logic [2:0]         dec_f_c;
  logic               dec_legal_c;
  logic               mismatch_c;

  // MIPS-style aluop/funct to ALU function code
  always_comb begin
    dec_f_c     = F_AND;
    dec_legal_c = 1'b1;
    unique case (req_aluop)
      2'b00: dec_f_c = F_ADD;
      2'b01: dec_f_c = F_SUB;
      2'b10: begin
        unique case (req_funct)
          6'b100000: dec_f_c = F_ADD;
          6'b100010: dec_f_c = F_SUB;
          6'b100100: dec_f_c = F_AND;
          6'b100101: dec_f_c = F_OR;
          6'b101010: dec_f_c = F_SLT;
          default:   dec_legal_c = 1'b0;
        endcase
      end
      default: dec_legal_c = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [WIDTH-1:0] exp_y_c;

  // Reference result from the operands currently driven onto the ALU
  always_comb begin
    exp_y_c = '0;
    unique case (alu_f_q)
      F_AND:   exp_y_c = alu_a_q & alu_b_q;
      F_OR:    exp_y_c = alu_a_q | alu_b_q;
      F_ADD:   exp_y_c = alu_a_q + alu_b_q;
      F_SUB:   exp_y_c = alu_a_q - alu_b_q;
      F_SLT:   exp_y_c = WIDTH'($signed(alu_a_q) < $signed(alu_b_q));
      default: exp_y_c = '0;
    endcase
    mismatch_c = (alu_y != exp_y_c) || (alu_zero != (exp_y_c == '0));
  end
`else
  assign mismatch_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_f_d        = alu_f_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_illegal_d  = rsp_illegal_q;
    rsp_mismatch_d = rsp_mismatch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d    = 1'b0;
          rsp_mismatch_d = 1'b0;
          if (dec_legal_c) begin
            alu_a_d = req_a;
            alu_b_d = req_b;
            alu_f_d = dec_f_c;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = ST_SETTLE;
          end else begin
            rsp_result_d  = '0;
            rsp_zero_d    = 1'b0;
            rsp_illegal_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_result_d   = alu_y;
          rsp_zero_d     = alu_zero;
          rsp_illegal_d  = 1'b0;
          rsp_mismatch_d = mismatch_c;
          rsp_valid_d    = 1'b1;
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_f_q        <= 3'b000;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_f_q        <= alu_f_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_illegal_q  <= rsp_illegal_d;
      rsp_mismatch_q <= rsp_mismatch_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_f        = alu_f_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign rsp_mismatch = rsp_mismatch_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1 driven by
// directed vectors, a second with SETTLE_CYCLES=4 for latency and mid-operation reset.
module tb_alu_op_sequencer;

  localparam int unsigned W = 32;
`ifdef ALU_SEQ_SELFCHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic         mismatch;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]   req_aluop;
  logic [5:0]   req_funct;
  logic [W-1:0] req_a, req_b, alu_a, alu_b, alu_y, rsp_result;
  logic [2:0]   alu_f;
  logic         alu_zero, rsp_zero, rsp_illegal, rsp_mismatch;
  logic         bad_alu;

  logic         q4_req_valid, q4_req_ready, q4_rsp_valid, q4_rsp_ready;
  logic [1:0]   q4_req_aluop;
  logic [5:0]   q4_req_funct;
  logic [W-1:0] q4_req_a, q4_req_b, q4_alu_a, q4_alu_b, q4_alu_y, q4_rsp_result;
  logic [2:0]   q4_alu_f;
  logic         q4_alu_zero, q4_rsp_zero, q4_rsp_illegal, q4_rsp_mismatch;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_a, last_b;
  logic [2:0]   last_f;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_illegal(rsp_illegal), .rsp_mismatch(rsp_mismatch)
  );

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(q4_req_valid), .req_ready(q4_req_ready), .req_aluop(q4_req_aluop),
    .req_funct(q4_req_funct), .req_a(q4_req_a), .req_b(q4_req_b),
    .alu_a(q4_alu_a), .alu_b(q4_alu_b), .alu_f(q4_alu_f), .alu_y(q4_alu_y), .alu_zero(q4_alu_zero),
    .rsp_valid(q4_rsp_valid), .rsp_ready(q4_rsp_ready), .rsp_result(q4_rsp_result),
    .rsp_zero(q4_rsp_zero), .rsp_illegal(q4_rsp_illegal), .rsp_mismatch(q4_rsp_mismatch)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Bench-side ALUs; bad_alu forces a wrong answer to provoke the self-check
  always_comb begin
    alu_y    = alu_fn(alu_a, alu_b, alu_f);
    alu_zero = (alu_y == '0);
    if (bad_alu) begin
      alu_y    = W'(1);
      alu_zero = 1'b1;
    end
  end

  always_comb begin
    q4_alu_y    = alu_fn(q4_alu_a, q4_alu_b, q4_alu_f);
    q4_alu_zero = (q4_alu_y == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a response is presented it must match the scoreboard head
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ready_valid_exclusive", W'(req_ready && rsp_valid), W'(0));
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%h expected=none", rsp_result);
        end else begin
          chk("rsp_result", rsp_result, sb_q[0].result);
          chk("rsp_zero", W'(rsp_zero), W'(sb_q[0].zero));
          chk("rsp_illegal", W'(rsp_illegal), W'(sb_q[0].illegal));
          chk("rsp_mismatch", W'(rsp_mismatch), W'(sb_q[0].mismatch));
          if (rsp_ready) sb_q.delete(0);
        end
      end
    end
  end

  task automatic run(input string name, input logic [1:0] op, input logic [5:0] fn,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                     input logic [W-1:0] res, input logic z, input logic ill, input logic mm,
                     input int hold, input logic bad);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_req_ready"}, W'(req_ready), W'(1));
    bad_alu   = bad;
    req_valid = 1'b1;
    req_aluop = op;
    req_funct = fn;
    req_a     = a;
    req_b     = b;
    e.result = res; e.zero = z; e.illegal = ill; e.mismatch = mm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hCAFE_F00D;
    req_aluop = 2'b00;
    if (!ill) begin
      last_a = a; last_b = b; last_f = f;
    end
    chk({name, "_alu_a"}, alu_a, last_a);
    chk({name, "_alu_b"}, alu_b, last_b);
    chk({name, "_alu_f"}, W'(alu_f), W'(last_f));
    chk({name, "_early_valid"}, W'(rsp_valid), W'(ill));
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_rsp_arrived"}, W'(rsp_valid), W'(1));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_ready_blocked"}, W'(req_ready), W'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    bad_alu   = 1'b0;
    chk({name, "_valid_drop"}, W'(rsp_valid), W'(0));
    chk({name, "_ready_back"}, W'(req_ready), W'(1));
  endtask

  task automatic chk_reset_vals(input string name, input logic rr, input logic rv,
                                input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                                input logic [W-1:0] r, input logic z, input logic il,
                                input logic mm);
    chk({name, "_req_ready"}, W'(rr), W'(1));
    chk({name, "_rsp_valid"}, W'(rv), W'(0));
    chk({name, "_alu_a"}, a, W'(0));
    chk({name, "_alu_b"}, b, W'(0));
    chk({name, "_alu_f"}, W'(f), W'(0));
    chk({name, "_rsp_result"}, r, W'(0));
    chk({name, "_rsp_zero"}, W'(z), W'(0));
    chk({name, "_rsp_illegal"}, W'(il), W'(0));
    chk({name, "_rsp_mismatch"}, W'(mm), W'(0));
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    req_valid = 1'b0; req_aluop = '0; req_funct = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; bad_alu = 1'b0;
    q4_req_valid = 1'b0; q4_req_aluop = '0; q4_req_funct = '0; q4_req_a = '0; q4_req_b = '0;
    q4_rsp_ready = 1'b1;
    last_a = '0; last_b = '0; last_f = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk_reset_vals("reset", req_ready, rsp_valid, alu_a, alu_b, alu_f, rsp_result, rsp_zero,
                   rsp_illegal, rsp_mismatch);

    run("add",      2'b00, 6'b000000, 32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("sub_zero", 2'b01, 6'b000000, 32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    run("f_and",    2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    run("f_or",     2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("f_slt",    2'b10, 6'b101010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b111, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run("f_add_wr", 2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run("f_sub_wr", 2'b10, 6'b100010, 32'h0000_0000, 32'h0000_0001, 3'b110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("ill_op11", 2'b11, 6'b100000, 32'h1111_1111, 32'h2222_2222, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    run("ill_fn",   2'b10, 6'b000000, 32'h3333_3333, 32'h4444_4444, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run("slt_neg_b",2'b10, 6'b101010, 32'h0000_0005, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run("bad_alu",  2'b00, 6'b000000, 32'h0000_0000, 32'h0000_0001, 3'b010, 32'h0000_0001, 1'b1, 1'b0, SC,   2, 1'b1);
    run("mm_clear", 2'b00, 6'b000000, 32'h0000_0007, 32'h0000_0007, 3'b010, 32'h0000_000E, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Four-edge settle latency on the second instance
    q4_req_valid = 1'b1; q4_req_aluop = 2'b00; q4_req_a = 32'h0000_0010; q4_req_b = 32'h0000_0020;
    @(posedge clk); #1;
    q4_req_valid = 1'b0;
    lat = 0;
    while (!q4_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("s4_latency", W'(lat), W'(4));
    chk("s4_result", q4_rsp_result, 32'h0000_0030);
    chk("s4_zero", W'(q4_rsp_zero), W'(0));
    @(posedge clk); #1;
    chk("s4_ready_back", W'(q4_req_ready), W'(1));

    // Reset pulse in the middle of SETTLE abandons the operation
    q4_req_valid = 1'b1; q4_req_aluop = 2'b01; q4_req_a = 32'h0000_0009; q4_req_b = 32'h0000_0002;
    @(posedge clk); #1;
    q4_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("s4_in_settle", W'(q4_alu_f), W'(3'b110));
    reset_n = 1'b0;
    #2;
    chk_reset_vals("s4_async_rst", q4_req_ready, q4_rsp_valid, q4_alu_a, q4_alu_b, q4_alu_f,
                   q4_rsp_result, q4_rsp_zero, q4_rsp_illegal, q4_rsp_mismatch);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("s4_no_rsp", W'(q4_rsp_valid), W'(0));
    end
    chk_reset_vals("s4_after_rst", q4_req_ready, q4_rsp_valid, q4_alu_a, q4_alu_b, q4_alu_f,
                   q4_rsp_result, q4_rsp_zero, q4_rsp_illegal, q4_rsp_mismatch);
    chk_reset_vals("main_after_rst", req_ready, rsp_valid, alu_a, alu_b, alu_f, rsp_result,
                   rsp_zero, rsp_illegal, rsp_mismatch);
    chk("sb_drained", W'(sb_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the team's 32-bit combinational ALU (f codes 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- Accepts operation requests on a valid/ready channel and decodes a MIPS-style aluop/funct pair into the 3-bit f code.
- Drives the registered a/b/f onto the ALU, waits a programmable settle time, then samples y/zero.
- Returns result, zero and status on a valid/ready response channel.
- Sits between the datapath control logic and the ALU. It is the ALU's only driver in multi-cycle test/datapath configurations.

Parameters:
WIDTH, 32, operand/result width in bits
SETTLE_CYCLES, 1, clock edges between driving the ALU and sampling alu_y/alu_zero; legal range 1..15

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_aluop  in  2  00=ADD, 01=SUB, 10=use funct, 11=illegal
req_funct  in  6  used when aluop=10
req_a  in  WIDTH  operand A
req_b  in  WIDTH  operand B
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_f  out  3  registered function code to ALU
alu_y  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  captured zero flag
rsp_illegal  out  1  request did not decode to a legal op
rsp_mismatch  out  1  self-check failure (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State goes to IDLE.
  - alu_a=0, alu_b=0, alu_f=3'b000.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, rsp_mismatch=0.
  - Reset mid-operation abandons the op; no response is produced.
- Decode:
  - aluop 00 -> f=010.
  - aluop 01 -> f=110.
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct, or aluop=11, is illegal.
- States:
  - IDLE:
    - req_ready=1, rsp_valid=0.
    - On req_valid&&req_ready with a legal op: register req_a/req_b/decoded f into alu_a/alu_b/alu_f, load cnt=SETTLE_CYCLES-1, go to SETTLE.
    - On an illegal op: alu_* hold their values; rsp_result=0, rsp_zero=0, rsp_illegal=1, rsp_mismatch=0; go to RESP.
  - SETTLE:
    - req_ready=0.
    - If cnt==0: capture alu_y into rsp_result and alu_zero into rsp_zero, set rsp_illegal=0, go to RESP.
    - Otherwise cnt decrements.
  - RESP:
    - rsp_valid=1, req_ready=0.
    - All rsp_* outputs held stable while rsp_ready=0.
    - On rsp_ready=1: go to IDLE.
- Latency: accept edge k -> capture at edge k+SETTLE_CYCLES -> rsp_valid high from that edge. Illegal ops: rsp_valid high at edge k+1.
- Throughput: one op per SETTLE_CYCLES+2 cycles at best. No request is accepted while a response is pending. req_ready and rsp_valid are never high together.
- alu_a/b/f hold their last values after an op completes; they change only on a legal accept or on reset.
- req_* inputs are ignored outside the accept edge.
- rsp_valid may stay high indefinitely; there is no timeout.

Optional Feature:
Macro ALU_SEQ_SELFCHECK_EN.
- Defined:
  - In SETTLE, on the capture edge, compute the expected result from alu_a/alu_b/alu_f:
    - AND, OR, ADD (mod 2^WIDTH), SUB (mod 2^WIDTH).
    - SLT = signed compare producing 1/0, zero-extended.
  - rsp_mismatch=1 if alu_y != expected, or if alu_zero != (expected==0).
  - Mismatch is registered with the response and cleared on the next accept.
- Undefined: the check logic is not compiled in and rsp_mismatch is tied to 0.

Test Plan:
- Reset then idle: reset_n low for 2 cycles -> req_ready=1, rsp_valid=0, alu_f=000, all rsp_* = 0.
- ADD: aluop=00, a=0x00000005, b=0x00000003, SETTLE_CYCLES=1 -> alu_f=010 one edge after accept; rsp_valid at accept+1 with rsp_result=0x00000008, rsp_zero=0.
- SUB to zero with backpressure: aluop=01, a=b=0x12345678, rsp_ready held 0 for 4 cycles -> rsp_result=0, rsp_zero=1, stable for all 4 cycles; req_ready=0 until the cycle after rsp_ready=1.
- funct decode: aluop=10 with funct 100100/100101/101010, a=0xF0F0F0F0, b=0x0FF00FF0 -> alu_f 000/001/111. Results 0x00F000F0, 0xFFF0FFF0, and 1 for SLT (a negative, b positive).
- Illegal: aluop=11, then aluop=10 with funct=000000 -> each gives a response one edge after accept with rsp_illegal=1, rsp_result=0; alu_a/b/f unchanged.
- Self-check (ALU_SEQ_SELFCHECK_EN) and reset mid-op: an ALU model returning y=1, zero=1 for a ADD b = 1 -> rsp_mismatch=1. With SETTLE_CYCLES=4 and reset_n pulsed low during SETTLE -> no rsp_valid ever; IDLE with all outputs at reset values.
